ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//   Receives PS/2 keyboard frames, decodes Set-2 make / break / extended
//   sequences and maps the 17 game keys onto a 5-bit key code.
//
// Ports
//   CLOCK_50     in   system clock, 50 MHz
//   resetn       in   asynchronous active-low reset
//   PS2_CLK      in   raw keyboard clock (asynchronous)
//   PS2_DAT      in   raw keyboard data  (asynchronous)
//   KEY_PRESSED  out  held key code 0..16, or IDLE_CODE when nothing is held
//   key_valid    out  one-cycle pulse on each accepted make of a mapped key
//   frame_err    out  one-cycle pulse on start/parity/stop error or timeout
//   scan_byte    out  last correctly received byte (debug)
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [4:0] IDLE_CODE      = 5'd31
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_valid,
  output logic       frame_err,
  output logic [7:0] scan_byte
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // -------------------------------------------------------------------------
  // Input synchronizers and falling-edge detect
  // -------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;
  logic       sync_clk;
  logic       sync_dat;
  logic       fall;

  // Idle PS/2 lines are high, so the synchronizers reset high to avoid a
  // spurious falling edge when reset is released.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign sync_clk = clk_sync_q[1];
  assign sync_dat = dat_sync_q[1];
  assign fall     = clk_prev_q & ~sync_clk;

  // -------------------------------------------------------------------------
  // Receiver FSM
  // -------------------------------------------------------------------------
  rx_state_e       rx_state_q;
  rx_state_e       rx_state_d;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [TW-1:0]   tmo_cnt_q;
  logic            tmo_expired;

  logic            clr_bits;
  logic            shift_en;
  logic            parity_en;
  logic            byte_ok;
  logic            byte_bad;

  logic            byte_rdy_q;
  logic            rx_err_q;

  // Only a partial frame can time out; idle gaps between frames are unbounded.
  assign tmo_expired = (rx_state_q != RX_IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) rx_state_q <= RX_IDLE;
    else         rx_state_q <= rx_state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    rx_state_d = rx_state_q;
    if (fall) begin
      unique case (rx_state_q)
        RX_IDLE:   if (!sync_dat) rx_state_d = RX_DATA;
        RX_DATA:   if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        RX_PARITY: rx_state_d = RX_STOP;
        RX_STOP:   rx_state_d = RX_IDLE;
        default:   rx_state_d = RX_IDLE;
      endcase
    end else if (tmo_expired) begin
      rx_state_d = RX_IDLE;
    end
  end

  always_comb begin
    clr_bits  = 1'b0;
    shift_en  = 1'b0;
    parity_en = 1'b0;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    if (fall) begin
      unique case (rx_state_q)
        RX_IDLE:   clr_bits  = ~sync_dat;
        RX_DATA:   shift_en  = 1'b1;
        RX_PARITY: parity_en = 1'b1;
        RX_STOP: begin
          // Odd parity: data bits plus parity bit carry an odd number of ones.
          byte_ok  = sync_dat & ((^shift_q) ^ parity_q);
          byte_bad = ~byte_ok;
        end
        default: ;
      endcase
    end else if (tmo_expired) begin
      byte_bad = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      byte_rdy_q <= 1'b0;
      rx_err_q   <= 1'b0;
      scan_byte  <= 8'h00;
    end else begin
      byte_rdy_q <= byte_ok;
      rx_err_q   <= byte_bad;
      if (clr_bits)      bit_cnt_q <= '0;
      else if (shift_en) bit_cnt_q <= bit_cnt_q + 3'd1;
      // LSB arrives first, so shift in from the top.
      if (shift_en)  shift_q  <= {sync_dat, shift_q[7:1]};
      if (parity_en) parity_q <= sync_dat;
      if (byte_ok)   scan_byte <= shift_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                           tmo_cnt_q <= '0;
    else if (fall || rx_state_q == RX_IDLE) tmo_cnt_q <= '0;
    else if (!tmo_expired)                 tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end

  // -------------------------------------------------------------------------
  // Scan-code decoder
  // -------------------------------------------------------------------------
  // Returns {hit, code}. The extended flag is part of the key so that E0 1D
  // and E0 1C do not alias onto the P1 keys.
  function automatic logic [5:0] lookup(input logic ext, input logic [7:0] b);
    logic [5:0] r;
    r = 6'd0;
    unique case ({ext, b})
      9'h01D: r = {1'b1, 5'd0};
      9'h01B: r = {1'b1, 5'd1};
      9'h01C: r = {1'b1, 5'd2};
      9'h023: r = {1'b1, 5'd3};
      9'h043: r = {1'b1, 5'd4};
      9'h042: r = {1'b1, 5'd5};
      9'h03B: r = {1'b1, 5'd6};
      9'h04B: r = {1'b1, 5'd7};
      9'h175: r = {1'b1, 5'd8};
      9'h172: r = {1'b1, 5'd9};
      9'h16B: r = {1'b1, 5'd10};
      9'h174: r = {1'b1, 5'd11};
      9'h075: r = {1'b1, 5'd12};
      9'h073: r = {1'b1, 5'd13};
      9'h06B: r = {1'b1, 5'd14};
      9'h074: r = {1'b1, 5'd15};
      9'h029: r = {1'b1, 5'd16};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  logic       ext_q;
  logic       brk_q;
  logic       lk_hit;
  logic [4:0] lk_code;

  assign {lk_hit, lk_code} = lookup(ext_q, scan_byte);

  // scan_byte and byte_rdy_q update on the same edge, so the decoder sees the
  // freshly received byte here.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      KEY_PRESSED <= IDLE_CODE;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= rx_err_q;
      if (byte_rdy_q) begin
        if (scan_byte == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (scan_byte == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (lk_hit) begin
            if (!brk_q) begin
              KEY_PRESSED <= lk_code;
              key_valid   <= 1'b1;
            end else if (lk_code == KEY_PRESSED) begin
              KEY_PRESSED <= IDLE_CODE;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int TMO = 600;   // shortened abort window keeps the run small
  localparam int H   = 8;     // PS/2 half-period in CLOCK_50 cycles

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [4:0] KEY_PRESSED;
  logic       key_valid;
  logic       frame_err;
  logic [7:0] scan_byte;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .IDLE_CODE(5'd31)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .PS2_CLK     (PS2_CLK),
    .PS2_DAT     (PS2_DAT),
    .KEY_PRESSED (KEY_PRESSED),
    .key_valid   (key_valid),
    .frame_err   (frame_err),
    .scan_byte   (scan_byte)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int kv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;

  always @(negedge CLOCK_50) begin
    if (key_valid)              kv_cnt   <= kv_cnt + 1;
    if (frame_err)              fe_cnt   <= fe_cnt + 1;
    if (key_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         map_hit  [0:1][0:255];
  logic [4:0] map_code [0:1][0:255];
  logic [4:0] m_key;
  bit         m_ext, m_brk;
  logic [7:0] m_scan;

  task automatic add_map(input int e, input int b, input int c);
    map_hit[e][b]  = 1'b1;
    map_code[e][b] = 5'(c);
  endtask

  task automatic model_reset();
    m_key = 5'd31; m_ext = 0; m_brk = 0; m_scan = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad, output int kv, output int fe);
    kv = 0; fe = 0;
    if (bad) begin
      fe = 1;
    end else begin
      m_scan = b;
      if (b == 8'hE0)      m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (map_hit[m_ext][b]) begin
          if (!m_brk) begin
            m_key = map_code[m_ext][b];
            kv = 1;
          end else if (map_code[m_ext][b] == m_key) begin
            m_key = 5'd31;
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (~^b) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input bit lat,
                           input logic [4:0] lat_old, input logic [4:0] lat_new);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      PS2_DAT = bits[i];
      repeat (H) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      if (lat && i == 10) begin
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("lat_edge3_key", KEY_PRESSED, lat_old);
        check("lat_edge3_kv", key_valid, 0);
        @(posedge CLOCK_50);
        #1;
        check("lat_edge4_key", KEY_PRESSED, lat_new);
        check("lat_edge4_kv", key_valid, 1);
      end
      repeat (H) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(frame_bits(b, bad_par, bad_stop), 11, 1'b0, 5'd0, 5'd0);
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn  = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);
  endtask

  // Sends one good frame and checks key plus pulse counts against constants.
  task automatic frame_expect(input string name, input logic [7:0] b,
                              input logic [4:0] key, input int kv, input int fe);
    int kv0, fe0;
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_frame(b, 1'b0, 1'b0);
    check({name, "_key"}, KEY_PRESSED, key);
    check({name, "_kv"}, kv_cnt - kv0, kv);
    check({name, "_fe"}, fe_cnt - fe0, fe);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    logic [4:0] key;
    int         kv;
    int         fe;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] b, input bit bp, input bit bs,
                         input logic [4:0] key, input int kv, input int fe);
    vec_t v;
    v.b = b; v.bad_par = bp; v.bad_stop = bs; v.key = key; v.kv = kv; v.fe = fe;
    vecs.push_back(v);
  endtask

  logic [7:0] pool[$];

  initial begin
    int kv0, fe0, kv_e, fe_e;
    logic [7:0] rb;
    bit bad, bp;

    for (int e = 0; e < 2; e++)
      for (int b = 0; b < 256; b++) begin
        map_hit[e][b] = 1'b0; map_code[e][b] = 5'd0;
      end
    add_map(0, 'h1D, 0);  add_map(0, 'h1B, 1);  add_map(0, 'h1C, 2);  add_map(0, 'h23, 3);
    add_map(0, 'h43, 4);  add_map(0, 'h42, 5);  add_map(0, 'h3B, 6);  add_map(0, 'h4B, 7);
    add_map(1, 'h75, 8);  add_map(1, 'h72, 9);  add_map(1, 'h6B, 10); add_map(1, 'h74, 11);
    add_map(0, 'h75, 12); add_map(0, 'h73, 13); add_map(0, 'h6B, 14); add_map(0, 'h74, 15);
    add_map(0, 'h29, 16);

    // Directed table, starting from KEY_PRESSED=31 with clear flags.
    add_vec(8'hE0, 0, 0, 5'd31, 0, 0);
    add_vec(8'h75, 0, 0, 5'd8,  1, 0);
    add_vec(8'hF0, 0, 0, 5'd8,  0, 0);
    add_vec(8'h75, 0, 0, 5'd8,  0, 0);  // non-extended break does not release P3 up
    add_vec(8'h75, 0, 0, 5'd12, 1, 0);
    add_vec(8'h43, 0, 0, 5'd4,  1, 0);
    add_vec(8'h23, 0, 0, 5'd3,  1, 0);
    add_vec(8'hF0, 0, 0, 5'd3,  0, 0);
    add_vec(8'h43, 0, 0, 5'd3,  0, 0);
    add_vec(8'h29, 1, 0, 5'd3,  0, 1);  // bad parity
    add_vec(8'h29, 0, 1, 5'd3,  0, 1);  // stop bit low
    add_vec(8'h1B, 0, 0, 5'd1,  1, 0);
    add_vec(8'h1B, 0, 0, 5'd1,  1, 0);
    add_vec(8'h1B, 0, 0, 5'd1,  1, 0);
    add_vec(8'h15, 0, 0, 5'd1,  0, 0);
    add_vec(8'hE0, 0, 0, 5'd1,  0, 0);
    add_vec(8'h1D, 0, 0, 5'd1,  0, 0);  // E0 1D is not P1 W
    add_vec(8'hE0, 0, 0, 5'd1,  0, 0);
    add_vec(8'h1C, 0, 0, 5'd1,  0, 0);  // E0 1C is not P1 A
    add_vec(8'hE1, 0, 0, 5'd1,  0, 0);
    add_vec(8'hE0, 0, 0, 5'd1,  0, 0);
    add_vec(8'hF0, 0, 0, 5'd1,  0, 0);
    add_vec(8'h75, 0, 0, 5'd1,  0, 0);
    add_vec(8'hF0, 0, 0, 5'd1,  0, 0);
    add_vec(8'h1B, 0, 0, 5'd31, 0, 0);
    add_vec(8'hE0, 0, 0, 5'd31, 0, 0);
    add_vec(8'h74, 0, 0, 5'd11, 1, 0);
    add_vec(8'hF0, 0, 0, 5'd11, 0, 0);
    add_vec(8'h6B, 0, 0, 5'd11, 0, 0);
    add_vec(8'hE0, 0, 0, 5'd11, 0, 0);
    add_vec(8'hF0, 0, 0, 5'd11, 0, 0);
    add_vec(8'h74, 0, 0, 5'd31, 0, 0);
    add_vec(8'h29, 0, 0, 5'd16, 1, 0);
    add_vec(8'hF0, 0, 0, 5'd16, 0, 0);
    add_vec(8'h29, 0, 0, 5'd31, 0, 0);

    // ---- reset state ----
    repeat (3) @(negedge CLOCK_50);
    check("rst_key", KEY_PRESSED, 5'd31);
    check("rst_kv", key_valid, 0);
    check("rst_fe", frame_err, 0);
    check("rst_scan", scan_byte, 8'h00);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // ---- reset mid-frame, then a clean frame ----
    send_bits(frame_bits(8'h1D, 0, 0), 5, 1'b0, 5'd0, 5'd0);
    do_reset();
    check("midrst_key", KEY_PRESSED, 5'd31);
    frame_expect("midrst_1d", 8'h1D, 5'd0, 1, 0);
    frame_expect("rel1_f0", 8'hF0, 5'd0, 0, 0);
    frame_expect("rel1_1d", 8'h1D, 5'd31, 0, 0);

    // ---- latency of the make, then its break ----
    kv0 = kv_cnt;
    send_bits(frame_bits(8'h1D, 0, 0), 11, 1'b1, 5'd31, 5'd0);
    repeat (2) @(negedge CLOCK_50);
    check("lat_kv_count", kv_cnt - kv0, 1);
    frame_expect("rel2_f0", 8'hF0, 5'd0, 0, 0);
    frame_expect("rel2_1d", 8'h1D, 5'd31, 0, 0);

    // ---- directed table ----
    foreach (vecs[i]) begin
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop);
      check($sformatf("vec%0d_key", i), KEY_PRESSED, vecs[i].key);
      check($sformatf("vec%0d_kv", i), kv_cnt - kv0, vecs[i].kv);
      check($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].fe);
    end

    // ---- timeout after 5 bits, then a good 29 ----
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_bits(frame_bits(8'h29, 0, 0), 5, 1'b0, 5'd0, 5'd0);
    repeat (TMO + 100) @(negedge CLOCK_50);
    check("tmo_fe", fe_cnt - fe0, 1);
    check("tmo_key", KEY_PRESSED, 5'd31);
    check("tmo_kv", kv_cnt - kv0, 0);
    frame_expect("tmo_29", 8'h29, 5'd16, 1, 0);

    // ---- randomized stream against the model ----
    do_reset();
    model_reset();
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43, 8'h42, 8'h3B, 8'h4B, 8'h75, 8'h73,
             8'h6B, 8'h74, 8'h72, 8'h29, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h15,
             8'hE1, 8'h00};
    for (int n = 0; n < 120; n++) begin
      rb  = pool[$urandom_range(0, pool.size() - 1)];
      bad = ($urandom_range(0, 9) == 0);
      bp  = bad && ($urandom_range(0, 1) == 1);
      model_byte(rb, bad, kv_e, fe_e);
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(rb, bp, bad && !bp);
      check($sformatf("rnd%0d_key", n), KEY_PRESSED, m_key);
      check($sformatf("rnd%0d_kv", n), kv_cnt - kv0, kv_e);
      check($sformatf("rnd%0d_fe", n), fe_cnt - fe0, fe_e);
      check($sformatf("rnd%0d_scan", n), scan_byte, m_scan);
    end

    check("kv_fe_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
